cache_meta_array: RTL and testbench
===================================

# cache_meta_array

Parametrised per-set/per-way metadata store for the set-associative data cache: valid and dirty bits for every line, a per-set replacement state and victim selector, and a flush engine that walks the array and hands every dirty line to the write-back unit. It sits beside the tag and data arrays in the cache controller. It replaces the single-bit-per-entry dirty store with a multi-way, replacement-aware, flushable array.

## Interface
- SETS, 8, number of sets; power of two, ≥2; IDX_W = log2(SETS)
- WAYS, 4, ways per set; power of two, ≥2; WAY_W = log2(WAYS)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- rd_idx  in  IDX_W  lookup set index
- rd_valid  out  WAYS  valid bits of set rd_idx, one per way (combinational)
- rd_dirty  out  WAYS  dirty bits of set rd_idx (combinational)
- victim_way  out  WAY_W  replacement choice for set rd_idx (combinational)
- wen  in  1  metadata write strobe
- w_idx  in  IDX_W  write set
- w_way  in  WAY_W  write way
- w_valid  in  1  new valid bit
- w_dirty  in  1  new dirty bit
- touch  in  1  with wen: access counts as a use for replacement
- flush_req  in  1  start a flush, sampled in IDLE only
- flush_busy  out  1  high from the cycle after flush_req is accepted through DONE
- wb_valid  out  1  dirty line offered to write-back
- wb_idx  out  IDX_W  offered set
- wb_way  out  WAY_W  offered way
- wb_ready  in  1  write-back accepts the offer
- flush_done  out  1  one-cycle pulse at flush completion

## Operation
- Storage: valid[SETS][WAYS], dirty[SETS][WAYS], plus repl[SETS] (width set by the Configuration section).
- Write: wen=1 while flush_busy=0 stores w_valid/w_dirty at [w_idx][w_way]; w_valid=0 forces the stored dirty bit to 0. wen is ignored while flush_busy=1; the controller stalls.
- Victim: the lowest-numbered way with valid=0; if every way is valid, the way the replacement state selects.
- Replacement update: applies only on wen & touch & !flush_busy, for set w_idx.
- Flush FSM states: IDLE, SCAN, OFFER, DONE.
  - IDLE: flush_req=1 → SCAN, with entry counter e=0. Entries are ordered set-major: set=e/WAYS, way=e%WAYS.
  - SCAN: examines one entry per cycle. If valid&dirty → OFFER. Otherwise, if e is the last entry (SETS*WAYS-1) → DONE; else e+1.
  - OFFER: wb_valid=1, with wb_idx/wb_way held stable. On wb_ready=1: clear that dirty bit (valid unchanged), then go to DONE if e is the last entry, else SCAN with e+1. Without wb_ready, hold indefinitely.
  - DONE: flush_done=1 for one cycle → IDLE.
- flush_req outside IDLE is ignored. The flush does not alter the replacement state.
- Reset: every valid, dirty and replacement bit goes to 0; FSM → IDLE; e=0; wb_valid, flush_busy and flush_done = 0. Reset mid-flush abandons the flush with no flush_done pulse.

## Timing
- Read path is combinational: rd_* and victim_way reflect state before the current edge. A write to the read set becomes visible the cycle after wen.
- Write and replacement-update latency: 1 cycle.
- Flush length = SETS*WAYS + (number of dirty lines) + total wb_ready stall cycles + 1 (DONE).
- wb_valid rises the cycle after SCAN finds the entry and falls the cycle after the handshake.
- flush_busy = (state != IDLE).

## Configuration
- CACHE_META_PLRU_EN defined: repl is a WAYS-1-bit tree pseudo-LRU per set.
  - Bit 0 is the root; 0 selects the lower half of the ways.
  - A victim walk follows the bits from the root down.
  - A touch sets every node on the touched way's path to point away from that way.
- Not defined: repl is a WAY_W-bit round-robin pointer per set.
  - The victim is the pointer value.
  - A touch on way == pointer advances the pointer by 1, mod WAYS.
  - A touch on any other way leaves the pointer unchanged.

## Test plan
- Reset, SETS=8, WAYS=4 → rd_valid=0000, rd_dirty=0000, victim_way=0, flush_busy=0 for every rd_idx.
- Write set 3: valid=1 in ways 0,1,3; dirty=1 in way 1 → set 3 reads rd_valid=1011, rd_dirty=0010, victim_way=2 (lowest invalid way). Then write w_valid=0, w_dirty=1 to way 1 → rd_dirty=0000.
- PLRU build, set 5 with all ways valid:
  - After reset, victim_way=0.
  - Touch way 0 → victim_way=2.
  - Touch way 2 → victim_way=1.
- Round-robin build, set 5 with all ways valid:
  - Touch ways 0,1 → victim_way=2.
  - Touch way 3 → victim_way stays 2.
- Flush with dirty lines at (set 0, way 2) and (set 7, way 3), wb_ready tied to 1:
  - Exactly two offers, in that order.
  - flush_done pulses once.
  - Total length 8*4+2+1=35 cycles.
  - Both lines afterwards: dirty=0, valid=1.
- Flush with wb_ready held low for 5 cycles on the first offer:
  - wb_idx and wb_way stay stable while held.
  - A wen issued during the flush has no effect.
  - Asserting rst mid-OFFER → wb_valid=0 the next cycle, no flush_done pulse, all bits cleared.

Source files
------------

// File: rtl/cache_meta_array.sv
// rtl/cache_meta_array.sv - per-set/per-way valid, dirty and replacement metadata with a dirty-line flush engine
//
// Purpose: metadata store beside the tag/data arrays of the set-associative
// data cache. Holds valid and dirty bits per line and a replacement state per
// set, and offers every dirty line to the write-back unit on a flush.
//
// Optional feature macro: CACHE_META_PLRU_EN
//   defined     -> per-set tree pseudo-LRU (WAYS-1 bits, bit 0 is the root)
//   not defined -> per-set round-robin pointer (WAY_W bits)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rd_idx                    lookup set
//   rd_valid, rd_dirty        per-way bits of set rd_idx (combinational)
//   victim_way                replacement choice for set rd_idx (combinational)
//   wen, w_idx, w_way,
//   w_valid, w_dirty, touch   metadata write; touch also updates replacement
//   flush_req                 start a flush (accepted only when idle)
//   flush_busy                flush engine not idle
//   wb_valid, wb_idx, wb_way  dirty line offered to write-back
//   wb_ready                  write-back accepts the offer
//   flush_done                one-cycle pulse at flush completion

module cache_meta_array #(
    parameter int SETS = 8,
    parameter int WAYS = 4,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WAYS-1:0]  rd_valid,
    output logic [WAYS-1:0]  rd_dirty,
    output logic [WAY_W-1:0] victim_way,
    input  logic             wen,
    input  logic [IDX_W-1:0] w_idx,
    input  logic [WAY_W-1:0] w_way,
    input  logic             w_valid,
    input  logic             w_dirty,
    input  logic             touch,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             wb_valid,
    output logic [IDX_W-1:0] wb_idx,
    output logic [WAY_W-1:0] wb_way,
    input  logic             wb_ready,
    output logic             flush_done
);

    localparam int E_W = IDX_W + WAY_W;
    localparam logic [E_W-1:0] E_LAST = E_W'(SETS * WAYS - 1);

`ifdef CACHE_META_PLRU_EN
    localparam int REPL_W = WAYS - 1;

    // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
    function automatic logic [WAY_W-1:0] repl_victim(input logic [REPL_W-1:0] t);
        int node;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            node = t[node] ? (2 * node + 2) : (2 * node + 1);
        end
        return WAY_W'(node - (WAYS - 1));
    endfunction

    // Every node on the touched way's path is pointed at the other subtree.
    function automatic logic [REPL_W-1:0] repl_touch(input logic [REPL_W-1:0] t,
                                                     input logic [WAY_W-1:0]  way);
        logic [REPL_W-1:0] r;
        logic              dir;
        int                node;
        r    = t;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir     = way[WAY_W-1-l];
            r[node] = ~dir;
            node    = 2 * node + 1 + int'(dir);
        end
        return r;
    endfunction
`else
    localparam int REPL_W = WAY_W;

    function automatic logic [WAY_W-1:0] repl_victim(input logic [REPL_W-1:0] t);
        return t;
    endfunction

    // Pointer only moves when the way it names is used.
    function automatic logic [REPL_W-1:0] repl_touch(input logic [REPL_W-1:0] t,
                                                     input logic [WAY_W-1:0]  way);
        return (way == t) ? (t + REPL_W'(1)) : t;
    endfunction
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_OFFER,
        ST_DONE
    } state_t;

    logic [SETS-1:0][WAYS-1:0]   valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0]   dirty_q, dirty_d;
    logic [SETS-1:0][REPL_W-1:0] repl_q, repl_d;
    state_t                      state_q, state_d;
    logic [E_W-1:0]              e_q, e_d;
    logic                        wb_valid_q, wb_valid_d;
    logic                        flush_busy_q, flush_busy_d;
    logic                        flush_done_q, flush_done_d;

    logic [IDX_W-1:0] e_set;
    logic [WAY_W-1:0] e_way;
    logic             e_hit;
    logic             busy;

    // Entries are walked set-major, so the counter splits directly into set/way.
    assign e_set = e_q[E_W-1:WAY_W];
    assign e_way = e_q[WAY_W-1:0];
    assign e_hit = valid_q[e_set][e_way] & dirty_q[e_set][e_way];
    assign busy  = (state_q != ST_IDLE);

    always_comb begin
        rd_valid   = valid_q[rd_idx];
        rd_dirty   = dirty_q[rd_idx];
        victim_way = repl_victim(repl_q[rd_idx]);
        // Descending walk so the lowest invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[rd_idx][w]) begin
                victim_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        repl_d  = repl_q;
        state_d = state_q;
        e_d     = e_q;

        // The controller stalls during a flush, so writes are dropped then.
        if (wen && !busy) begin
            valid_d[w_idx][w_way] = w_valid;
            dirty_d[w_idx][w_way] = w_valid & w_dirty;
            if (touch) begin
                repl_d[w_idx] = repl_touch(repl_q[w_idx], w_way);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_SCAN;
                    e_d     = '0;
                end
            end
            ST_SCAN: begin
                if (e_hit) begin
                    state_d = ST_OFFER;
                end else if (e_q == E_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    e_d = e_q + E_W'(1);
                end
            end
            ST_OFFER: begin
                if (wb_ready) begin
                    dirty_d[e_set][e_way] = 1'b0;
                    if (e_q == E_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                        e_d     = e_q + E_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wb_valid_d   = (state_d == ST_OFFER);
        flush_busy_d = (state_d != ST_IDLE);
        flush_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            dirty_q      <= '0;
            repl_q       <= '0;
            state_q      <= ST_IDLE;
            e_q          <= '0;
            wb_valid_q   <= 1'b0;
            flush_busy_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            repl_q       <= repl_d;
            state_q      <= state_d;
            e_q          <= e_d;
            wb_valid_q   <= wb_valid_d;
            flush_busy_q <= flush_busy_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign flush_busy = flush_busy_q;
    assign flush_done = flush_done_q;
    assign wb_idx     = e_set;
    assign wb_way     = e_way;

endmodule

// File: tb/tb_cache_meta_array.sv
// tb/tb_cache_meta_array.sv - scoreboard bench for cache_meta_array against a behavioural model

module tb_cache_meta_array;

    localparam int SETS  = 8;
    localparam int WAYS  = 4;
    localparam int IDX_W = 3;
    localparam int WAY_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [IDX_W-1:0] rd_idx;
    logic [WAYS-1:0]  rd_valid;
    logic [WAYS-1:0]  rd_dirty;
    logic [WAY_W-1:0] victim_way;
    logic             wen;
    logic [IDX_W-1:0] w_idx;
    logic [WAY_W-1:0] w_way;
    logic             w_valid;
    logic             w_dirty;
    logic             touch;
    logic             flush_req;
    logic             flush_busy;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic [WAY_W-1:0] wb_way;
    logic             wb_ready;
    logic             flush_done;

    cache_meta_array #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_dirty(rd_dirty),
        .victim_way(victim_way), .wen(wen), .w_idx(w_idx), .w_way(w_way), .w_valid(w_valid),
        .w_dirty(w_dirty), .touch(touch), .flush_req(flush_req), .flush_busy(flush_busy),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_way(wb_way), .wb_ready(wb_ready),
        .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int              idx;
        logic [WAYS-1:0] v;
        logic [WAYS-1:0] d;
        int              victim;
    } rd_exp_t;

    typedef struct {
        int idx;
        int way;
    } wb_exp_t;

    rd_exp_t rd_q[$];
    wb_exp_t wb_q[$];
    logic    probe_en = 1'b0;

    // Reference model: plain per-line bits plus an abstract replacement state.
    bit m_valid[SETS][WAYS];
    bit m_dirty[SETS][WAYS];
`ifdef CACHE_META_PLRU_EN
    // m_node[level][prefix]: 1 means "victim lies in the upper child of this subtree".
    bit m_node[SETS][WAY_W][WAYS];
`else
    int m_ptr[SETS];
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
`ifdef CACHE_META_PLRU_EN
            for (int l = 0; l < WAY_W; l++)
                for (int p = 0; p < WAYS; p++)
                    m_node[s][l][p] = 1'b0;
`else
            m_ptr[s] = 0;
`endif
        end
    endtask

    function automatic int m_victim(input int s);
`ifdef CACHE_META_PLRU_EN
        int p;
`endif
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[s][w]) return w;
`ifdef CACHE_META_PLRU_EN
        p = 0;
        for (int l = 0; l < WAY_W; l++)
            p = 2 * p + int'(m_node[s][l][p]);
        return p;
`else
        return m_ptr[s];
`endif
    endfunction

    task automatic m_touch(input int s, input int w);
`ifdef CACHE_META_PLRU_EN
        for (int l = 0; l < WAY_W; l++)
            m_node[s][l][w >> (WAY_W - l)] = (((w >> (WAY_W - 1 - l)) & 1) == 0);
`else
        if (w == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic do_write(input int s, input int w, input bit v, input bit d, input bit t);
        wen     = 1'b1;
        w_idx   = IDX_W'(s);
        w_way   = WAY_W'(w);
        w_valid = v;
        w_dirty = d;
        touch   = t;
        @(posedge clk); #1;
        wen   = 1'b0;
        touch = 1'b0;
        m_valid[s][w] = v;
        m_dirty[s][w] = v & d;
        if (t) m_touch(s, w);
    endtask

    task automatic probe(input int s);
        rd_exp_t e;
        rd_idx = IDX_W'(s);
        e.idx  = s;
        for (int w = 0; w < WAYS; w++) begin
            e.v[w] = m_valid[s][w];
            e.d[w] = m_dirty[s][w];
        end
        e.victim = m_victim(s);
        rd_q.push_back(e);
        probe_en = 1'b1;
        @(negedge clk); #1;
        probe_en = 1'b0;
    endtask

    // mode 0: ready always; mode 1: hold ready low 5 cycles on the first offer; mode 2: random stalls.
    task automatic run_flush(input int mode, input int wen_at, output int busy, output int stalls);
        wb_exp_t e;
        int      done;
        int      ndirty;
        int      stall_left;
        bit      finished;
        busy       = 0;
        stalls     = 0;
        done       = 0;
        ndirty     = 0;
        finished   = 1'b0;
        stall_left = (mode == 1) ? 5 : 0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (m_dirty[s][w]) begin
                    e.idx = s;
                    e.way = w;
                    wb_q.push_back(e);
                    ndirty++;
                end
        wb_ready  = 1'b1;
        flush_req = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            flush_req = 1'b0;
            wen       = 1'b0;
            touch     = 1'b0;
            if (!flush_busy) begin
                finished = 1'b1;
                break;
            end
            busy++;
            if (flush_done) done++;
            if (c == wen_at) begin
                wen     = 1'b1;
                w_idx   = 3'd7;
                w_way   = 2'd3;
                w_valid = 1'b0;
                w_dirty = 1'b0;
                touch   = 1'b1;
            end
            wb_ready = 1'b1;
            if (wb_valid) begin
                if (mode == 1 && stall_left > 0) begin
                    wb_ready = 1'b0;
                    stall_left--;
                end else if (mode == 2 && $urandom_range(0, 2) == 0) begin
                    wb_ready = 1'b0;
                end
            end
            if (!wb_ready) stalls++;
        end
        wb_ready = 1'b1;
        check("flush_finished", finished, 1);
        check("flush_length", busy, SETS * WAYS + ndirty + stalls + 1);
        check("flush_done_pulses", done, 1);
        check("flush_offers_missing", wb_q.size(), 0);
        wb_q.delete();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                m_dirty[s][w] = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a probe is presented or a write-back handshake occurs.
    logic             pv = 1'b0;
    logic             pr = 1'b0;
    logic [IDX_W-1:0] pi = '0;
    logic [WAY_W-1:0] pw = '0;

    initial begin : monitor
        rd_exp_t re;
        wb_exp_t we;
        forever begin
            @(negedge clk);
            if (probe_en) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_scoreboard actual=probe expected=queued_entry");
                end else begin
                    re = rd_q.pop_front();
                    check($sformatf("rd_valid_set%0d", re.idx), rd_valid, re.v);
                    check($sformatf("rd_dirty_set%0d", re.idx), rd_dirty, re.d);
                    check($sformatf("victim_set%0d", re.idx), victim_way, re.victim);
                end
            end
            if (wb_valid && wb_ready) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected actual=%0d/%0d expected=no_offer", wb_idx, wb_way);
                end else begin
                    we = wb_q.pop_front();
                    check("wb_idx", wb_idx, we.idx);
                    check("wb_way", wb_way, we.way);
                end
            end
            if (wb_valid && pv && !pr) begin
                check("wb_idx_hold", wb_idx, pi);
                check("wb_way_hold", wb_way, pw);
            end
            pv = wb_valid;
            pr = wb_ready;
            pi = wb_idx;
            pw = wb_way;
        end
    end

    initial begin : main
        int busy;
        int stalls;
        int done_seen;
        int wb_seen;
        bit found;

        rst       = 1'b1;
        rd_idx    = '0;
        wen       = 1'b0;
        w_idx     = '0;
        w_way     = '0;
        w_valid   = 1'b0;
        w_dirty   = 1'b0;
        touch     = 1'b0;
        flush_req = 1'b0;
        wb_ready  = 1'b1;

        do_reset();
        check("rst_flush_busy", flush_busy, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_flush_done", flush_done, 0);
        for (int s = 0; s < SETS; s++) probe(s);

        do_write(3, 0, 1, 0, 0);
        do_write(3, 1, 1, 1, 0);
        do_write(3, 3, 1, 0, 0);
        probe(3);
        check("set3_valid", rd_valid, 4'b1011);
        check("set3_dirty", rd_dirty, 4'b0010);
        check("set3_victim", victim_way, 2);
        do_write(3, 1, 0, 1, 0);
        probe(3);
        check("set3_invalid_clears_dirty", rd_dirty, 4'b0000);

        for (int w = 0; w < WAYS; w++) do_write(5, w, 1, 0, 0);
        probe(5);
        check("repl_initial", victim_way, 0);
`ifdef CACHE_META_PLRU_EN
        do_write(5, 0, 1, 0, 1);
        probe(5);
        check("plru_touch0", victim_way, 2);
        do_write(5, 2, 1, 0, 1);
        probe(5);
        check("plru_touch2", victim_way, 1);
`else
        do_write(5, 0, 1, 0, 1);
        do_write(5, 1, 1, 0, 1);
        probe(5);
        check("rr_touch01", victim_way, 2);
        do_write(5, 3, 1, 0, 1);
        probe(5);
        check("rr_touch3", victim_way, 2);
`endif

        for (int i = 0; i < 250; i++) begin
            int s;
            int w;
            s = $urandom_range(0, SETS - 1);
            w = $urandom_range(0, WAYS - 1);
            do_write(s, w, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            probe(s);
            if (i % 8 == 0) probe($urandom_range(0, SETS - 1));
        end
        run_flush(2, -1, busy, stalls);
        for (int s = 0; s < SETS; s++) probe(s);

        do_reset();
        do_write(0, 2, 1, 1, 0);
        do_write(7, 3, 1, 1, 0);
        do_write(2, 1, 1, 0, 0);
        do_write(4, 0, 1, 0, 1);
        run_flush(0, -1, busy, stalls);
        check("flush_two_dirty_len35", busy, 35);
        for (int s = 0; s < SETS; s++) probe(s);

        do_write(0, 2, 1, 1, 0);
        do_write(7, 3, 1, 1, 0);
        run_flush(1, 4, busy, stalls);
        check("flush_stall_count", stalls, 5);
        check("flush_stall_len40", busy, 40);
        probe(7);
        probe(0);

        do_reset();
        do_write(1, 1, 1, 1, 0);
        do_write(6, 0, 1, 1, 0);
        wb_ready  = 1'b0;
        flush_req = 1'b1;
        found     = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            flush_req = 1'b0;
            if (wb_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("offer_seen", found, 1);
        check("offer_first_idx", wb_idx, 1);
        check("offer_first_way", wb_way, 1);
        repeat (3) @(posedge clk);
        #1;
        check("offer_held", wb_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        wb_q.delete();
        check("midflush_rst_wb_valid", wb_valid, 0);
        check("midflush_rst_busy", flush_busy, 0);
        wb_ready  = 1'b1;
        done_seen = 0;
        wb_seen   = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (flush_done) done_seen++;
            if (wb_valid) wb_seen++;
        end
        check("midflush_rst_no_done", done_seen, 0);
        check("midflush_rst_no_offer", wb_seen, 0);
        for (int s = 0; s < SETS; s++) probe(s);

        check("rd_scoreboard_drained", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
